// File: rtl/escaper.sv
// escaper: AXI4-Stream byte stuffer that prefixes reserved bytes with ESCAPE_BYTE
module escaper #(
  parameter logic [7:0] ESCAPE_BYTE = 8'h7F,
  parameter logic [7:0] START_BYTE  = 8'h7D,
  parameter logic [7:0] STOP_BYTE   = 8'h7E
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       target_tvalid,
  output logic       target_tready,
  input  logic [7:0] target_tdata,
  input  logic       target_tlast,
  output logic       initiator_tvalid,
  input  logic       initiator_tready,
  output logic [7:0] initiator_tdata,
  output logic       initiator_tlast
);
  typedef enum logic {PASS, HOLD} state_t;
  state_t     state, state_d;
  logic [7:0] hold_data, hold_data_d, tdata_d;
  logic       hold_last, hold_last_d, tvalid_d, tlast_d;
  logic       free, accept, reserved;
  assign free          = !initiator_tvalid || initiator_tready;
  assign target_tready = aresetn && state == PASS && free;
  assign accept        = target_tvalid && target_tready;
  assign reserved      = target_tdata == ESCAPE_BYTE || target_tdata == START_BYTE || target_tdata == STOP_BYTE;
  // next state, output register load and hold register capture
  always_comb begin
    state_d     = state;
    tvalid_d    = initiator_tvalid;
    tdata_d     = initiator_tdata;
    tlast_d     = initiator_tlast;
    hold_data_d = hold_data;
    hold_last_d = hold_last;
    if (state == PASS) begin
      if (accept) begin
        tvalid_d    = 1'b1;
        tdata_d     = reserved ? ESCAPE_BYTE : target_tdata;
        tlast_d     = reserved ? 1'b0 : target_tlast;
        hold_data_d = reserved ? target_tdata : hold_data;
        hold_last_d = reserved ? target_tlast : hold_last;
        state_d     = reserved ? HOLD : PASS;
      end else if (free) begin
        tvalid_d = 1'b0;
      end
    end else if (initiator_tready) begin
      tvalid_d = 1'b1;
      tdata_d  = hold_data;
      tlast_d  = hold_last;
      state_d  = PASS;
    end
  end
  // state and registers; reset drops any pending escape and held byte
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state            <= PASS;
      initiator_tvalid <= 1'b0;
      initiator_tdata  <= 8'h00;
      initiator_tlast  <= 1'b0;
      hold_data        <= 8'h00;
      hold_last        <= 1'b0;
    end else begin
      state            <= state_d;
      initiator_tvalid <= tvalid_d;
      initiator_tdata  <= tdata_d;
      initiator_tlast  <= tlast_d;
      hold_data        <= hold_data_d;
      hold_last        <= hold_last_d;
    end
  end
endmodule
